// File: rtl/efpga_coproc_bridge.sv
`default_nettype none
// ============================================================================
// Module  : efpga_coproc_bridge
// Brief   : CPU-to-eFPGA coprocessor bridge. A req/gnt/rvalid register port
//           loads operands, operator code and delay. START strobes the fabric,
//           and the job completes on a fabric done pulse or after a fixed
//           delay, with an optional timeout. Results are captured and sticky
//           DONE/TIMEOUT flags drive a level interrupt.
// Revision: 1.0 - initial release
// ============================================================================
module efpga_coproc_bridge #(
    parameter int NUM_OPERANDS = 2,
    parameter int NUM_RESULTS  = 3,
    parameter int OP_W         = 2,
    parameter int DELAY_W      = 4,
    parameter int TIMEOUT_W    = 8
) (
    input  logic                      clk_i,
    input  logic                      reset,
    input  logic                      req_i,
    input  logic [5:0]                addr_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic [NUM_OPERANDS*32-1:0] eFPGA_operand_o,
    input  logic [NUM_RESULTS*32-1:0] eFPGA_result_i,
    output logic                      eFPGA_write_strobe_o,
    input  logic                      eFPGA_fpga_done_i,
    output logic                      eFPGA_en_o,
    output logic [OP_W-1:0]           eFPGA_operator_o,
    output logic [DELAY_W-1:0]        eFPGA_delay_o,
    output logic                      irq_o
);

    // Wait counter must cover both the fixed delay and the timeout limit.
    localparam int c_cnt_w = (DELAY_W > TIMEOUT_W) ? DELAY_W : TIMEOUT_W;

    localparam logic [5:0] c_addr_ctrl   = 6'h00;
    localparam logic [5:0] c_addr_status = 6'h01;
    localparam logic [5:0] c_addr_tlimit = 6'h02;
    localparam logic [5:0] c_addr_opnd   = 6'h10;
    localparam logic [5:0] c_addr_res    = 6'h20;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_rvalid;
    logic [31:0]            r_rdata;
    logic                   r_mode;
    logic                   r_irq_en;
    logic [OP_W-1:0]        r_operator;
    logic [DELAY_W-1:0]     r_delay;
    logic [TIMEOUT_W-1:0]   r_tlimit;
    logic [31:0]            r_operand [NUM_OPERANDS];
    logic [31:0]            r_result  [NUM_RESULTS];
    logic                   r_done;
    logic                   r_timeout;
    logic                   r_strobe;
    logic                   r_en;
    logic [c_cnt_w-1:0]     r_cnt;

    logic                   w_wr;
    logic                   w_rd;
    logic                   w_busy;
    logic                   w_wr_ctrl;
    logic                   w_wr_status;
    logic                   w_wr_tlimit;
    logic                   w_start;
    logic                   w_complete;
    logic                   w_tmo;
    logic [31:0]            w_bemask;
    logic [31:0]            w_ctrl_img;
    logic [31:0]            w_rdata;
    logic [OP_W-1:0]        w_operator_next;
    logic [DELAY_W-1:0]     w_delay_next;
    logic [TIMEOUT_W-1:0]   w_tlimit_next;
    logic [c_cnt_w-1:0]     w_delay_ext;
    logic [c_cnt_w-1:0]     w_tlimit_ext;
    logic [c_cnt_w-1:0]     w_delay_tgt;
    logic [c_cnt_w-1:0]     w_tlimit_tgt;

    // Every request is granted in the cycle it is presented.
    assign gnt_o    = req_i;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;

    assign w_wr        = req_i & we_i;
    assign w_rd        = req_i & ~we_i;
    assign w_busy      = (r_state != S_IDLE);
    assign w_wr_ctrl   = w_wr & (addr_i == c_addr_ctrl);
    assign w_wr_status = w_wr & (addr_i == c_addr_status);
    assign w_wr_tlimit = w_wr & (addr_i == c_addr_tlimit);
    assign w_start     = w_wr_ctrl & be_i[0] & wdata_i[0] & ~w_busy;

    assign w_bemask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

    // A zero delay behaves as a one-cycle delay; the counter starts at 0.
    assign w_delay_ext  = c_cnt_w'(r_delay);
    assign w_tlimit_ext = c_cnt_w'(r_tlimit);
    assign w_delay_tgt  = (r_delay == '0) ? '0 : (w_delay_ext - c_cnt_w'(1));
    assign w_tlimit_tgt = w_tlimit_ext - c_cnt_w'(1);

    // Fabric done is only honoured in wait-done mode; timeout loses to done.
    assign w_complete = (r_state == S_WAIT) &
                        (r_mode ? (r_cnt == w_delay_tgt) : eFPGA_fpga_done_i);
    assign w_tmo      = (r_state == S_WAIT) & ~r_mode & (r_tlimit != '0) &
                        (r_cnt == w_tlimit_tgt) & ~eFPGA_fpga_done_i;

    assign eFPGA_write_strobe_o = r_strobe;
    assign eFPGA_en_o           = r_en;
    assign eFPGA_operator_o     = r_operator;
    assign eFPGA_delay_o        = r_delay;
    assign irq_o                = r_irq_en & (r_done | r_timeout);

    generate
        for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_operand_out
            assign eFPGA_operand_o[32*gi +: 32] = r_operand[gi];
        end
    endgenerate

    // Byte-masked next values for the narrow CTRL and TIMEOUT_LIMIT fields.
    always_comb begin
        w_operator_next = r_operator;
        w_delay_next    = r_delay;
        w_tlimit_next   = r_tlimit;
        for (int k = 0; k < OP_W; k++) begin
            if (w_bemask[8+k]) w_operator_next[k] = wdata_i[8+k];
        end
        for (int k = 0; k < DELAY_W; k++) begin
            if (w_bemask[16+k]) w_delay_next[k] = wdata_i[16+k];
        end
        for (int k = 0; k < TIMEOUT_W; k++) begin
            if (w_bemask[k]) w_tlimit_next[k] = wdata_i[k];
        end
    end

    // CTRL read image; START always reads back as 0.
    always_comb begin
        w_ctrl_img                = '0;
        w_ctrl_img[1]             = r_mode;
        w_ctrl_img[2]             = r_irq_en;
        w_ctrl_img[8 +: OP_W]     = r_operator;
        w_ctrl_img[16 +: DELAY_W] = r_delay;
    end

    // Read data mux; unmapped words return 0.
    always_comb begin
        w_rdata = '0;
        if (addr_i == c_addr_ctrl) begin
            w_rdata = w_ctrl_img;
        end else if (addr_i == c_addr_status) begin
            w_rdata = {29'd0, r_timeout, r_done, w_busy};
        end else if (addr_i == c_addr_tlimit) begin
            w_rdata = 32'(r_tlimit);
        end
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (addr_i == (c_addr_opnd + 6'(i))) w_rdata = r_operand[i];
        end
        for (int j = 0; j < NUM_RESULTS; j++) begin
            if (addr_i == (c_addr_res + 6'(j))) w_rdata = r_result[j];
        end
    end

    // Bus response: one cycle after each accepted request, data only for reads.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    // Configuration and operand registers; CTRL and operands freeze while busy.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_mode     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_operator <= '0;
            r_delay    <= '0;
            r_tlimit   <= '0;
            for (int i = 0; i < NUM_OPERANDS; i++) r_operand[i] <= '0;
        end else begin
            if (w_wr_ctrl && !w_busy) begin
                if (be_i[0]) begin
                    r_mode   <= wdata_i[1];
                    r_irq_en <= wdata_i[2];
                end
                r_operator <= w_operator_next;
                r_delay    <= w_delay_next;
            end
            if (w_wr_tlimit) r_tlimit <= w_tlimit_next;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (w_wr && !w_busy && (addr_i == (c_addr_opnd + 6'(i)))) begin
                    r_operand[i] <= (r_operand[i] & ~w_bemask) | (wdata_i & w_bemask);
                end
            end
        end
    end

    // Job sequencer with status flags and result capture; hardware sets
    // are written after the W1C clears so they take precedence.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_strobe  <= 1'b0;
            r_en      <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            for (int j = 0; j < NUM_RESULTS; j++) r_result[j] <= '0;
        end else begin
            r_strobe <= 1'b0;
            if (w_wr_status) begin
                if (wdata_i[1]) r_done    <= 1'b0;
                if (wdata_i[2]) r_timeout <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_STROBE;
                        r_strobe  <= 1'b1;
                        r_en      <= 1'b1;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_STROBE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_complete) begin
                        r_state <= S_IDLE;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                        for (int j = 0; j < NUM_RESULTS; j++) begin
                            r_result[j] <= eFPGA_result_i[32*j +: 32];
                        end
                    end else if (w_tmo) begin
                        r_state   <= S_IDLE;
                        r_en      <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_efpga_coproc_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_efpga_coproc_bridge
// Brief   : Directed, table-driven bench for efpga_coproc_bridge with
//           hand-written cycle sequences for job timing and corner cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_efpga_coproc_bridge;

    logic         clk_i = 1'b0;
    logic         rst_n;
    logic         req;
    logic [5:0]   addr;
    logic         we;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic         gnt_o;
    logic         rvalid_o;
    logic [31:0]  rdata_o;
    logic [63:0]  operand_o;
    logic [95:0]  result;
    logic         strobe_o;
    logic         fdone;
    logic         en_o;
    logic [1:0]   operator_o;
    logic [3:0]   delay_o;
    logic         irq_o;

    int n_pass  = 0;
    int n_total = 0;

    efpga_coproc_bridge #(
        .NUM_OPERANDS (2),
        .NUM_RESULTS  (3),
        .OP_W         (2),
        .DELAY_W      (4),
        .TIMEOUT_W    (8)
    ) dut (
        .clk_i                (clk_i),
        .reset                (rst_n),
        .req_i                (req),
        .addr_i               (addr),
        .we_i                 (we),
        .be_i                 (be),
        .wdata_i              (wdata),
        .gnt_o                (gnt_o),
        .rvalid_o             (rvalid_o),
        .rdata_o              (rdata_o),
        .eFPGA_operand_o      (operand_o),
        .eFPGA_result_i       (result),
        .eFPGA_write_strobe_o (strobe_o),
        .eFPGA_fpga_done_i    (fdone),
        .eFPGA_en_o           (en_o),
        .eFPGA_operator_o     (operator_o),
        .eFPGA_delay_o        (delay_o),
        .irq_o                (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One bus transaction: request in one cycle, response sampled in the next.
    task automatic bus(input logic w, input logic [5:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk_i);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1;
        chk("gnt", {63'd0, gnt_o}, 64'd1);
        @(posedge clk_i);
        #1;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        chk("rvalid", {63'd0, rvalid_o}, 64'd1);
        rd = rdata_o;
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] rd;
        bus(1'b1, a, b, d, rd);
        chk($sformatf("wr_rdata_%0h", a), {32'd0, rd}, 64'd0);
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bus(1'b0, a, 4'h0, 32'd0, rd);
        chk(name, {32'd0, rd}, {32'd0, exp});
    endtask

    // Called right after the START write returns (k=1 is the strobe cycle).
    // Checks {strobe,en,irq} each cycle; done_k drives fabric done in that cycle.
    task automatic watch(input string tag, input int ncyc, input int done_k,
                         input int en_last, input int irq_first);
        logic [2:0] exp;
        for (int k = 1; k <= ncyc; k++) begin
            fdone = (k == done_k);
            exp[2] = (k == 1);
            exp[1] = (k <= en_last);
            exp[0] = (irq_first != 0) && (k >= irq_first);
            chk($sformatf("%s_c%0d", tag, k), {61'd0, strobe_o, en_o, irq_o}, {61'd0, exp});
            @(posedge clk_i);
            #1;
        end
        fdone = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        vecs[0]  = '{1'b1, 6'h10, 4'hF, 32'h0000_0011, 32'h0};
        vecs[1]  = '{1'b1, 6'h11, 4'hF, 32'h0000_0022, 32'h0};
        vecs[2]  = '{1'b0, 6'h10, 4'h0, 32'h0,         32'h0000_0011};
        vecs[3]  = '{1'b0, 6'h11, 4'h0, 32'h0,         32'h0000_0022};
        vecs[4]  = '{1'b1, 6'h10, 4'h2, 32'hAAAA_BBCC, 32'h0};
        vecs[5]  = '{1'b0, 6'h10, 4'h0, 32'h0,         32'h0000_BB11};
        vecs[6]  = '{1'b1, 6'h10, 4'hF, 32'h0000_0011, 32'h0};
        vecs[7]  = '{1'b1, 6'h02, 4'hF, 32'h0000_0055, 32'h0};
        vecs[8]  = '{1'b1, 6'h02, 4'h2, 32'h0000_0808, 32'h0};
        vecs[9]  = '{1'b0, 6'h02, 4'h0, 32'h0,         32'h0000_0055};
        vecs[10] = '{1'b1, 6'h02, 4'h1, 32'h0000_0008, 32'h0};
        vecs[11] = '{1'b0, 6'h02, 4'h0, 32'h0,         32'h0000_0008};
        vecs[12] = '{1'b1, 6'h20, 4'hF, 32'h0000_DEAD, 32'h0};
        vecs[13] = '{1'b0, 6'h20, 4'h0, 32'h0,         32'h0};
        vecs[14] = '{1'b1, 6'h05, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[15] = '{1'b0, 6'h05, 4'h0, 32'h0,         32'h0};
        vecs[16] = '{1'b0, 6'h3F, 4'h0, 32'h0,         32'h0};
        vecs[17] = '{1'b1, 6'h00, 4'h2, 32'h0000_0301, 32'h0};
        vecs[18] = '{1'b0, 6'h01, 4'h0, 32'h0,         32'h0};
        vecs[19] = '{1'b0, 6'h00, 4'h0, 32'h0,         32'h0000_0300};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        fdone = 1'b0; result = '0;
        repeat (3) @(posedge clk_i);
        #1;
        // Reset state
        chk("rst_ctl_outs", {59'd0, gnt_o, rvalid_o, strobe_o, en_o, irq_o}, 64'd0);
        chk("rst_rdata", {32'd0, rdata_o}, 64'd0);
        chk("rst_operand", operand_o, 64'd0);
        chk("rst_op_delay", {58'd0, operator_o, delay_o}, 64'd0);
        @(negedge clk_i);
        rst_n = 1'b1;

        // Register map vectors
        for (int i = 0; i < 20; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd);
            chk($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].exp});
        end
        chk("operand_o", operand_o, {32'h22, 32'h11});
        chk("operator_o_t1", {62'd0, operator_o}, 64'd3);
        chk("irq_idle", {63'd0, irq_o}, 64'd0);

        // Wait-done job, done four cycles after the strobe
        result = {32'd3, 32'd2, 32'd1};
        wr(6'h00, 4'hF, 32'h0000_0205);
        watch("waitdone", 7, 5, 5, 6);
        result = {32'hBAD, 32'hBAD, 32'hBAD};
        rd_chk("res0", 6'h20, 32'd1);
        rd_chk("res1", 6'h21, 32'd2);
        rd_chk("res2", 6'h22, 32'd3);
        rd_chk("status_done", 6'h01, 32'h2);
        rd_chk("ctrl_rb", 6'h00, 32'h0000_0204);
        chk("operator_o_t2", {62'd0, operator_o}, 64'd2);

        // Fixed delay 5 and delay 0
        result = {32'd3, 32'd2, 32'd1};
        wr(6'h00, 4'hF, 32'h0005_0007);
        chk("delay_o", {60'd0, delay_o}, 64'd5);
        watch("dly5", 9, 0, 6, 7);
        wr(6'h00, 4'hF, 32'h0000_0007);
        watch("dly0", 5, 0, 2, 3);
        rd_chk("status_dly0", 6'h01, 32'h2);

        // Timeout after 8 wait cycles, then done on the 8th cycle wins
        result = {32'd9, 32'd9, 32'd9};
        wr(6'h00, 4'hF, 32'h0000_0005);
        watch("tmo", 11, 0, 9, 10);
        rd_chk("status_tmo", 6'h01, 32'h4);
        rd_chk("res0_tmo", 6'h20, 32'd1);
        wr(6'h00, 4'hF, 32'h0000_0005);
        watch("tmo_done", 11, 9, 9, 10);
        rd_chk("status_tmo_done", 6'h01, 32'h2);
        rd_chk("res0_tmo_done", 6'h20, 32'd9);

        // Writes while busy are dropped; W1C in the set cycle loses
        result = {32'd7, 32'd6, 32'd5};
        wr(6'h00, 4'hF, 32'h0000_0201);
        rd_chk("status_busy", 6'h01, 32'h1);
        wr(6'h10, 4'hF, 32'h0000_00FF);
        wr(6'h00, 4'hF, 32'h0003_0303);
        chk("busy_en", {63'd0, en_o}, 64'd1);
        fdone = 1'b1;
        wr(6'h01, 4'hF, 32'h0000_0002);
        fdone = 1'b0;
        rd_chk("status_w1c_race", 6'h01, 32'h2);
        rd_chk("opnd0_busy", 6'h10, 32'h11);
        rd_chk("res2_busy", 6'h22, 32'd7);
        chk("operator_busy", {62'd0, operator_o}, 64'd2);
        wr(6'h01, 4'hF, 32'h0000_0002);
        rd_chk("status_w1c", 6'h01, 32'h0);

        // Reset during WAIT
        wr(6'h00, 4'hF, 32'h0000_0305);
        repeat (3) @(posedge clk_i);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", {59'd0, rvalid_o, strobe_o, en_o, irq_o, gnt_o}, 64'd0);
        chk("arst_operand", operand_o, 64'd0);
        chk("arst_op_delay", {58'd0, operator_o, delay_o}, 64'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        rd_chk("arst_ctrl", 6'h00, 32'h0);
        rd_chk("arst_status", 6'h01, 32'h0);
        rd_chk("arst_tlimit", 6'h02, 32'h0);
        rd_chk("arst_opnd0", 6'h10, 32'h0);
        rd_chk("arst_res0", 6'h20, 32'h0);

        // Clean job after reset release
        result = {32'd30, 32'd20, 32'd10};
        wr(6'h10, 4'hF, 32'h0000_0007);
        wr(6'h00, 4'hF, 32'h0002_0007);
        watch("post_rst", 6, 0, 3, 4);
        rd_chk("post_res1", 6'h21, 32'd20);
        rd_chk("post_status", 6'h01, 32'h2);
        chk("post_operand", operand_o, {32'h0, 32'h7});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
